mux_scan_ctrl: RTL
==================

Name: mux_scan_ctrl

Overview:
Sequencer directly upstream of the NAND-based 4:1 mux. Drives the mux select lines s1/s0 through channels 0..3 and holds each channel for a programmable settle (dwell) time. Samples the mux output y at the end of each dwell and packs the four samples into a 4-bit frame. Delivers the frame over a valid/ready handshake. Supports single-shot and continuous scanning.

Parameters:
DWELL, 2, clock cycles each channel is held before its sample is taken; legal range 1..255
CNT_W, $clog2(DWELL) with minimum 1, dwell counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a scan; sampled only in IDLE
cont  input  1  continuous mode; sampled at each scan completion
abort  input  1  synchronous; discards the partial scan and returns to IDLE
y_in  input  1  mux output y
s0  output  1  mux select bit 0 (sel[0])
s1  output  1  mux select bit 1 (sel[1])
frame  output  4  completed frame; frame[n] = y_in sampled while sel==n
frame_valid  output  1  frame holds unconsumed data
frame_ready  input  1  downstream accepts frame
busy  output  1  high in SCAN or STALL

Behaviour:
- Reset: async, applies immediately. State=IDLE, sel=0 (s1=s0=0), cnt=0, shadow=0, frame=0, frame_valid=0, busy=0.
- States: IDLE, SCAN, STALL.
- IDLE: sel held at 0. start=1 at edge k -> SCAN with sel=0 and cnt=0 from cycle k+1. busy=1 from k+1.
- SCAN: cnt increments each cycle.
  - At the edge where cnt==DWELL-1: shadow[sel] <= y_in, cnt <= 0.
  - If sel<3: sel <= sel+1.
  - If sel==3: scan completes.
  - Each channel therefore lasts exactly DWELL cycles. The channel-3 sample lands at edge k+4*DWELL.
- Completion, at the same edge as the channel-3 sample:
  - The output register is free when frame_valid==0, or frame_valid==1 with frame_ready==1 in that cycle.
  - If free: frame <= {y_in, shadow[2:0]} and frame_valid <= 1. Then, if cont==1, go to SCAN with sel=0 and cnt=0; otherwise go to IDLE.
  - If not free: go to STALL with sel held at 3 and the completed frame held in shadow.
- STALL: on the first cycle the output register is free, transfer shadow to frame and set frame_valid=1. Then go to SCAN if cont==1, else IDLE. No frame is ever dropped or overwritten.
- Handshake: frame_valid && frame_ready at an edge constitutes a transfer. frame_valid clears unless it is reloaded at the same edge (reload wins). frame is stable while frame_valid=1 and frame_ready=0.
- start while busy: ignored.
- abort:
  - Has priority over start and over completion.
  - In SCAN or STALL: next state is IDLE, sel=0, cnt=0, shadow contents are don't-care.
  - frame and frame_valid are untouched.
  - In IDLE: no effect.
- DWELL==1: every cycle is a sample edge and the counter is constant 0.
- s1/s0 come directly from registered sel and are glitch-free.
- rst asserted mid-scan: everything returns to reset values asynchronously, including an unconsumed frame.

Decomposition:
- Package mux_scan_pkg:
  - state enum (IDLE, SCAN, STALL)
  - NUM_CH=4
  - SEL_W=2
  - DWELL_MAX=255
- One sub-module, mux_dwell_timer:
  - counter with clear/enable
  - terminal-count output (cnt==DWELL-1)
  - parameterised by DWELL
- Top module holds the FSM, sel, shadow and the output register.

Test Plan:
- DWELL=2, frame_ready=1, behavioural mux model with i0..i3=1,0,1,1, start pulse at cycle 0 -> sel sequence 0,0,1,1,2,2,3,3 over cycles 1..8; frame=4'b1101 with frame_valid=1 at cycle 9; busy=0 and state IDLE at cycle 9.
- cont=1, frame_ready=1, inputs changed to 0,1,1,0 during the second scan -> back-to-back frames 4'b1101 then 4'b0110, one every 8 cycles, sel wraps 3->0 with no idle cycle.
- cont=1, frame_ready=0 for 20 cycles -> first frame valid and held stable; second scan enters STALL with sel=3. Raise frame_ready -> first frame transferred, second frame loaded at that same edge, frame_valid stays 1, scan resumes.
- abort asserted at cycle 4 of a scan (sel=1) with a prior frame 4'b1010 pending -> IDLE next cycle, sel=0, busy=0; frame stays 4'b1010 with frame_valid=1.
- rst asserted asynchronously mid-scan and mid-cycle -> all outputs 0 immediately, before the next clock edge; start pulses during the scan are ignored.
- DWELL=1 -> sel 0,1,2,3 on consecutive cycles; frame valid 4 cycles after start is accepted.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam int NUM_CH    = 4;
    localparam int SEL_W     = 2;
    localparam int DWELL_MAX = 255;

    // Counter width for a dwell of n cycles; a dwell of 1 still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the last cycle.
module mux_dwell_timer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int              CNT_W  = cnt_width(DWELL);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = (cnt == TC_VAL);

    // Wraps to zero on terminal count so back-to-back channels need no clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the 4:1 mux select through all channels, samples y_in after each
// dwell and hands the packed 4-bit frame downstream over valid/ready.
//
// state | meaning
// IDLE  | sel parked at 0, waiting for start
// SCAN  | sel stepping 0..3, one sample per dwell
// STALL | scan complete, frame parked in shadow until output register frees
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       abort,
    input  logic       y_in,
    output logic       s0,
    output logic       s1,
    output logic [3:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    state_t            state, state_n;
    logic [SEL_W-1:0]  sel, sel_n;
    logic [NUM_CH-1:0] shadow, shadow_n;
    logic [3:0]        frame_n;
    logic              frame_valid_n;
    logic              tmr_clr, tmr_en, tmr_tc;
    logic              out_free;

    mux_dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .tc  (tmr_tc)
    );

    assign out_free = !frame_valid || frame_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= '0;
            shadow      <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
        end else begin
            state       <= state_n;
            sel         <= sel_n;
            shadow      <= shadow_n;
            frame       <= frame_n;
            frame_valid <= frame_valid_n;
        end
    end

    always_comb begin
        state_n       = state;
        sel_n         = sel;
        shadow_n      = shadow;
        frame_n       = frame;
        // A handshake drains the register; a reload below overrides this.
        frame_valid_n = frame_valid && !frame_ready;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;

        unique case (state)
            IDLE: begin
                sel_n   = '0;
                tmr_clr = 1'b1;
                if (start) begin
                    state_n = SCAN;
                end
            end

            SCAN: begin
                tmr_en = 1'b1;
                if (abort) begin
                    state_n = IDLE;
                    sel_n   = '0;
                    tmr_clr = 1'b1;
                end else if (tmr_tc) begin
                    shadow_n[sel] = y_in;
                    if (sel != LAST_CH) begin
                        sel_n = sel + SEL_W'(1);
                    end else if (out_free) begin
                        frame_n       = {y_in, shadow[2:0]};
                        frame_valid_n = 1'b1;
                        sel_n         = '0;
                        state_n       = cont ? SCAN : IDLE;
                    end else begin
                        state_n = STALL;
                    end
                end
            end

            STALL: begin
                tmr_clr = 1'b1;
                if (abort) begin
                    state_n = IDLE;
                    sel_n   = '0;
                end else if (out_free) begin
                    frame_n       = shadow;
                    frame_valid_n = 1'b1;
                    sel_n         = '0;
                    state_n       = cont ? SCAN : IDLE;
                end
            end

            default: begin
                state_n = IDLE;
                sel_n   = '0;
                tmr_clr = 1'b1;
            end
        endcase
    end

    assign s0   = sel[0];
    assign s1   = sel[1];
    assign busy = (state != IDLE);

endmodule
